// File: rtl/vvcar_input_pkg.sv
// rtl/vvcar_input_pkg.sv - scan codes, coin FSM states, key vector and IN0/IN1 bit map
// Shared by ps2_key_latch and vvcar_input_ctrl; no ports.
package vvcar_input_pkg;

  // {extended, code}; arrows are matched on the low 8 bits only
  localparam logic [8:0] KC_UP    = 9'h075;
  localparam logic [8:0] KC_DOWN  = 9'h072;
  localparam logic [8:0] KC_LEFT  = 9'h06B;
  localparam logic [8:0] KC_RIGHT = 9'h074;
  localparam logic [8:0] KC_SPACE = 9'h029;
  localparam logic [8:0] KC_CTRL  = 9'h014;
  localparam logic [8:0] KC_F1    = 9'h005;
  localparam logic [8:0] KC_F2    = 9'h006;
  localparam logic [8:0] KC_F3    = 9'h004;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  localparam int IN0_UP     = 0;
  localparam int IN0_LEFT   = 1;
  localparam int IN0_RIGHT  = 2;
  localparam int IN0_DOWN   = 3;
  localparam int IN0_FIRE   = 4;
  localparam int IN0_COIN   = 5;
  localparam int IN1_START1 = 5;
  localparam int IN1_START2 = 6;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic fire;
    logic start1;
    logic start2;
    logic svc;
  } key_vec_t;

endpackage

// File: rtl/vvcar_input_ctrl_ps2_key_latch.sv
// rtl/vvcar_input_ctrl_ps2_key_latch.sv - PS/2 event detection and per-key press latches
// Ports: clk, rst_n (async, active-low), ps2_key[64:0] (bit 64 toggles per event),
//        keys (packed key_vec_t of latched key states).
// Macro SERVICE_COIN_EN adds the F3 latch; otherwise keys.svc is tied low.
module ps2_key_latch
  import vvcar_input_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [64:0] ps2_key,
  output key_vec_t    keys
);

  logic       toggle_q, toggle_d;
  logic       primed_q, primed_d;
  key_vec_t   keys_q, keys_d;
  logic       pressed;
  logic       extended;
  logic       key_event;
  logic [7:0] code;
  logic [8:0] xcode;

  always_comb begin
    pressed   = (ps2_key[15:8] != 8'hF0);
    extended  = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    // Any payload above the 3-byte window is not a key we decode.
    code      = (ps2_key[63:24] != 40'd0) ? 8'h00 : ps2_key[7:0];
    xcode     = {extended, code};
    // The toggle copy is unknown until the first cycle after reset.
    key_event = primed_q && (ps2_key[64] != toggle_q);
    primed_d  = 1'b1;
    toggle_d  = ps2_key[64];
    keys_d    = keys_q;
    if (key_event) begin
      if (code == KC_UP[7:0])    keys_d.up    = pressed;
      if (code == KC_DOWN[7:0])  keys_d.down  = pressed;
      if (code == KC_LEFT[7:0])  keys_d.left  = pressed;
      if (code == KC_RIGHT[7:0]) keys_d.right = pressed;
      if (xcode == KC_SPACE || xcode == KC_CTRL) keys_d.fire = pressed;
      if (xcode == KC_F1) keys_d.start1 = pressed;
      if (xcode == KC_F2) keys_d.start2 = pressed;
`ifdef SERVICE_COIN_EN
      if (xcode == KC_F3) keys_d.svc = pressed;
`endif
    end
`ifndef SERVICE_COIN_EN
    keys_d.svc = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= 1'b0;
      primed_q <= 1'b0;
      keys_q   <= '0;
    end else begin
      toggle_q <= toggle_d;
      primed_q <= primed_d;
      keys_q   <= keys_d;
    end
  end

  assign keys = keys_q;

endmodule

// File: rtl/vvcar_input_ctrl.sv
// rtl/vvcar_input_ctrl.sv - Van-Van Car input conditioner: keys+joysticks, rotation, coin pulses
// Ports: CLK, RESET_N (async, active-low), PS2_KEY[64:0], JOY0/JOY1[15:0], ROTATE,
//        VBLANK (rising edge = frame tick), IN0/IN1 (active-low core inputs), COIN_BUSY.
// Macro SERVICE_COIN_EN: coins come from F3 / joy[7] edges instead of start edges.
module vvcar_input_ctrl
  import vvcar_input_pkg::*;
#(
  parameter int COIN_FRAMES     = 3,
  parameter int COIN_GAP_FRAMES = 6,
  parameter int COIN_QUEUE_MAX  = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [64:0] PS2_KEY,
  input  logic [15:0] JOY0,
  input  logic [15:0] JOY1,
  input  logic        ROTATE,
  input  logic        VBLANK,
  output logic [7:0]  IN0,
  output logic [7:0]  IN1,
  output logic        COIN_BUSY
);

  key_vec_t    keys;
  logic [15:0] joy;
  logic        up_c, down_c, left_c, right_c, fire_c, start1_c, start2_c;
  logic        up_m, down_m, left_m, right_m;
  logic        req_any, req_edge, tick, gate;
  logic        vbl_q, vbl_d, vbl2_q, vbl2_d;
  logic        req_prev_q, req_prev_d;
  coin_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  queue_q, queue_d;
  logic [7:0]  in0_q, in0_d, in1_q, in1_d;
  logic        unused_bits;

  ps2_key_latch u_keys (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .ps2_key (PS2_KEY),
    .keys    (keys)
  );

  always_comb begin
    joy      = JOY0 | JOY1;
    up_c     = keys.up     | joy[3];
    down_c   = keys.down   | joy[2];
    left_c   = keys.left   | joy[1];
    right_c  = keys.right  | joy[0];
    fire_c   = keys.fire   | joy[4];
    start1_c = keys.start1 | joy[5];
    start2_c = keys.start2 | joy[6];

    // Horizontal monitor: the cabinet is turned a quarter, so directions rotate.
    if (ROTATE) begin
      up_m    = left_c;
      down_m  = right_c;
      left_m  = down_c;
      right_m = up_c;
    end else begin
      up_m    = up_c;
      down_m  = down_c;
      left_m  = left_c;
      right_m = right_c;
    end

`ifdef SERVICE_COIN_EN
    req_any = keys.svc | joy[7];
`else
    req_any = start1_c | start2_c;
`endif
    req_prev_d = req_any;
    req_edge   = req_any & ~req_prev_q;

    vbl_d  = VBLANK;
    vbl2_d = vbl_q;
    tick   = vbl_q & ~vbl2_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    queue_d = queue_q;
    case (state_q)
      IDLE: begin
        if (req_edge || queue_q != 3'd0) begin
          state_d = PULSE;
          cnt_d   = 4'(COIN_FRAMES);
          // A fresh edge replaces the dequeued entry, leaving the count as is.
          if (queue_q != 3'd0 && !req_edge) queue_d = queue_q - 3'd1;
        end
      end
      PULSE, GAP: begin
        if (tick) begin
          if (cnt_q == 4'd1) begin
            state_d = (state_q == PULSE) ? GAP : IDLE;
            cnt_d   = 4'(COIN_GAP_FRAMES);
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        if (req_edge && queue_q != 3'(COIN_QUEUE_MAX)) queue_d = queue_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are taken from the next state so coin, gating and COIN_BUSY line up.
    gate = (state_d != IDLE) || (queue_d != 3'd0);

    in0_d            = 8'hFF;
    in0_d[IN0_UP]    = ~up_m;
    in0_d[IN0_LEFT]  = ~left_m;
    in0_d[IN0_RIGHT] = ~right_m;
    in0_d[IN0_DOWN]  = ~down_m;
    in0_d[IN0_FIRE]  = ~fire_c;
    in0_d[IN0_COIN]  = ~(state_d == PULSE);

    in1_d             = 8'hFF;
    in1_d[IN1_START1] = ~(start1_c & ~gate);
    in1_d[IN1_START2] = ~(start2_c & ~gate);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vbl_q      <= 1'b0;
      vbl2_q     <= 1'b0;
      req_prev_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      queue_q    <= 3'd0;
      in0_q      <= 8'hFF;
      in1_q      <= 8'hFF;
    end else begin
      vbl_q      <= vbl_d;
      vbl2_q     <= vbl2_d;
      req_prev_q <= req_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      queue_q    <= queue_d;
      in0_q      <= in0_d;
      in1_q      <= in1_d;
    end
  end

  assign IN0       = in0_q;
  assign IN1       = in1_q;
  assign COIN_BUSY = (state_q != IDLE);

`ifdef SERVICE_COIN_EN
  assign unused_bits = &{1'b0, joy[15:8]};
`else
  assign unused_bits = &{1'b0, joy[15:7], keys.svc};
`endif

endmodule

// File: tb/tb_vvcar_input_ctrl.sv
// tb/tb_vvcar_input_ctrl.sv - self-checking bench for vvcar_input_ctrl
module tb_vvcar_input_ctrl;

  localparam int CF = 3;
  localparam int GF = 6;
  localparam int QM = 3;
  localparam int P  = 8;
`ifdef SERVICE_COIN_EN
  localparam int         REQ_BIT   = 7;
  localparam int         OTHER_BIT = 5;
  localparam logic [7:0] IN1_HELD  = 8'hFF;
`else
  localparam int         REQ_BIT   = 5;
  localparam int         OTHER_BIT = 7;
  localparam logic [7:0] IN1_HELD  = 8'hDF;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [64:0] PS2_KEY = '0;
  logic [15:0] JOY0 = '0;
  logic [15:0] JOY1 = '0;
  logic        ROTATE = 1'b0;
  logic        VBLANK = 1'b0;
  logic [7:0]  IN0;
  logic [7:0]  IN1;
  logic        COIN_BUSY;

  vvcar_input_ctrl dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .PS2_KEY   (PS2_KEY),
    .JOY0      (JOY0),
    .JOY1      (JOY1),
    .ROTATE    (ROTATE),
    .VBLANK    (VBLANK),
    .IN0       (IN0),
    .IN1       (IN1),
    .COIN_BUSY (COIN_BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         klat [8];   // up, down, left, right, fire, start1, start2, service
  bit         m_tog, m_primed, m_v1, m_v2, m_req_prev;
  int         coin_left, gap_left, pend;
  logic [7:0] exp_in0 = 8'hFF;
  logic [7:0] exp_in1 = 8'hFF;
  logic       exp_busy = 1'b0;
  logic [15:0] m_joy;
  bit         u, d, l, r, f, s1, s2, eu, ed, el, er;
  bit         m_req, m_edge, m_tick, m_busy, m_gated, m_pressed, m_ext;
  logic [7:0] m_code;
  int         m_slot;

  function automatic int slot_of(input logic [8:0] xc);
    if (xc[7:0] == 8'h75) return 0;
    if (xc[7:0] == 8'h72) return 1;
    if (xc[7:0] == 8'h6B) return 2;
    if (xc[7:0] == 8'h74) return 3;
    if (xc == 9'h029 || xc == 9'h014) return 4;
    if (xc == 9'h005) return 5;
    if (xc == 9'h006) return 6;
`ifdef SERVICE_COIN_EN
    if (xc == 9'h004) return 7;
`endif
    return -1;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      foreach (klat[i]) klat[i] = 1'b0;
      m_tog = 0; m_primed = 0; m_v1 = 0; m_v2 = 0; m_req_prev = 0;
      coin_left = 0; gap_left = 0; pend = 0;
      exp_in0 = 8'hFF; exp_in1 = 8'hFF; exp_busy = 1'b0;
    end else begin
      m_joy = JOY0 | JOY1;
      u  = klat[0] | m_joy[3];
      d  = klat[1] | m_joy[2];
      l  = klat[2] | m_joy[1];
      r  = klat[3] | m_joy[0];
      f  = klat[4] | m_joy[4];
      s1 = klat[5] | m_joy[5];
      s2 = klat[6] | m_joy[6];
`ifdef SERVICE_COIN_EN
      m_req = klat[7] | m_joy[7];
`else
      m_req = s1 | s2;
`endif
      m_edge = m_req && !m_req_prev;
      m_tick = m_v1 && !m_v2;
      if (coin_left == 0 && gap_left == 0) begin
        if (m_edge || pend > 0) begin
          coin_left = CF;
          if (pend > 0 && !m_edge) pend--;
        end
      end else begin
        if (m_tick) begin
          if (coin_left > 0) begin
            coin_left--;
            if (coin_left == 0) gap_left = GF;
          end else begin
            gap_left--;
          end
        end
        if (m_edge && pend < QM) pend++;
      end
      m_busy  = (coin_left > 0) || (gap_left > 0);
      m_gated = m_busy || (pend > 0);
      {eu, ed, el, er} = ROTATE ? {l, r, d, u} : {u, d, l, r};
      exp_in0  = ~{2'b00, coin_left > 0, f, ed, er, el, eu};
      exp_in1  = ~{1'b0, s2 && !m_gated, s1 && !m_gated, 5'b0};
      exp_busy = m_busy;
      if (m_primed && PS2_KEY[64] != m_tog) begin
        m_pressed = PS2_KEY[15:8] != 8'hF0;
        m_ext     = m_pressed ? (PS2_KEY[15:8] == 8'hE0) : (PS2_KEY[23:16] == 8'hE0);
        m_code    = (PS2_KEY[63:24] != 40'd0) ? 8'h00 : PS2_KEY[7:0];
        m_slot    = slot_of({m_ext, m_code});
        if (m_slot >= 0) klat[m_slot] = m_pressed;
      end
      m_primed   = 1;
      m_tog      = PS2_KEY[64];
      m_v2       = m_v1;
      m_v1       = VBLANK;
      m_req_prev = m_req;
    end
  end

  always @(negedge CLK) begin
    chk("in0", {24'd0, IN0}, {24'd0, exp_in0});
    chk("in1", {24'd0, IN1}, {24'd0, exp_in1});
    chk("coin_busy", {31'd0, COIN_BUSY}, {31'd0, exp_busy});
  end

  // ---------------- stimulus ----------------
  int frame_ph = 0;
  bit vbl_auto = 1;
  int coin_cyc, gap_cyc, pulses;
  bit prev_coin;
  bit in1_ok;
  logic [7:0] codes [10];
  int mode;

  task automatic step();
    @(posedge CLK);
    #3;
    if (vbl_auto) begin
      frame_ph = (frame_ph + 1) % P;
      VBLANK   = (frame_ph < 2);
    end
  endtask

  task automatic zero_counts();
    coin_cyc = 0; gap_cyc = 0; pulses = 0; prev_coin = 0; in1_ok = 1;
  endtask

  task automatic cstep();
    step();
    if (!IN0[5]) begin
      coin_cyc++;
      if (!prev_coin) pulses++;
    end else if (COIN_BUSY) begin
      gap_cyc++;
    end
    if (COIN_BUSY && IN1 != 8'hFF) in1_ok = 0;
    prev_coin = !IN0[5];
  endtask

  task automatic tap(input int b);
    JOY0[b] = 1'b1;
    cstep();
    JOY0[b] = 1'b0;
    cstep();
  endtask

  initial begin
    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06, 8'h04, 8'h11};

    // reset with the toggle bit high and an up code present
    PS2_KEY = {1'b1, 40'd0, 8'h00, 8'h00, 8'h75};
    RESET_N = 1'b0;
    step(); step();
    chk("rst_in0", {24'd0, IN0}, 32'hFF);
    chk("rst_in1", {24'd0, IN1}, 32'hFF);
    chk("rst_busy", {31'd0, COIN_BUSY}, 32'd0);
    RESET_N = 1'b1;
    step(); step(); step();
    chk("prime_no_event", {24'd0, IN0}, 32'hFF);

    // PS/2 up press then release
    PS2_KEY[64] = 1'b0;
    step();
    chk("ps2_lat_1cyc", {24'd0, IN0}, 32'hFF);
    step();
    chk("ps2_up_press", {24'd0, IN0}, 32'hFE);
    PS2_KEY = {1'b1, 40'd0, 8'h00, 8'hF0, 8'h75};
    step(); step();
    chk("ps2_up_release", {24'd0, IN0}, 32'hFF);

    // rotation
    ROTATE = 1'b1; JOY0 = 16'h0002;
    step();
    chk("rot_left_is_up", {24'd0, IN0}, 32'hFE);
    ROTATE = 1'b0;
    step();
    chk("direct_left", {24'd0, IN0}, 32'hFD);
    JOY0 = 16'h0000;
    step(); step();

    // held coin request: one pulse, then the gap, then start visible
    zero_counts();
    JOY0[REQ_BIT] = 1'b1;
    for (int i = 0; i < 150; i++) cstep();
    chk("held_pulses", pulses, 1);
    chk("held_coin_len", {31'd0, coin_cyc > 2 * P && coin_cyc <= 3 * P}, 1);
    chk("held_gap_len", gap_cyc, GF * P);
    chk("held_in1_gated", {31'd0, in1_ok}, 1);
    chk("held_in1_after", {24'd0, IN1}, {24'd0, IN1_HELD});
    chk("held_idle", {31'd0, COIN_BUSY}, 0);
    JOY0[REQ_BIT] = 1'b0;
    step(); step();

    // one request plus five during the pulse: queue saturates
    zero_counts();
    for (int i = 0; i < 6; i++) tap(REQ_BIT);
    for (int i = 0; i < 400; i++) cstep();
    chk("sat_pulses", pulses, 1 + QM);
    chk("sat_gap_total", gap_cyc, (1 + QM) * GF * P);
    chk("sat_idle", {31'd0, COIN_BUSY}, 0);

    // the other bit never requests a coin
    zero_counts();
    tap(OTHER_BIT);
    for (int i = 0; i < 60; i++) cstep();
    chk("other_bit_no_coin", pulses, 0);

    // reset in the middle of a pulse with a queued request
    zero_counts();
    tap(REQ_BIT);
    tap(REQ_BIT);
    step(); step(); step();
    chk("mid_pulse_coin", {31'd0, IN0[5]}, 0);
    RESET_N = 1'b0;
    #1;
    chk("reset_drops_coin", {24'd0, IN0}, 32'hFF);
    chk("reset_drops_busy", {31'd0, COIN_BUSY}, 0);
    step(); step();
    RESET_N = 1'b1;
    zero_counts();
    for (int i = 0; i < 250; i++) cstep();
    chk("queue_lost", pulses, 0);

    // randomized traffic, checked every cycle by the model
    vbl_auto = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) VBLANK = ~VBLANK;
      if ($urandom_range(0, 11) == 0)
        JOY0 = 16'($urandom) & (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'h00FF);
      if ($urandom_range(0, 11) == 0)
        JOY1 = 16'($urandom) & (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'h00FF);
      if ($urandom_range(0, 31) == 0) ROTATE = 1'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        PS2_KEY[63:0] = '0;
        PS2_KEY[7:0]  = codes[$urandom_range(0, 9)];
        mode = $urandom_range(0, 3);
        case (mode)
          1: PS2_KEY[15:8] = 8'hE0;
          2: begin
            PS2_KEY[15:8]  = 8'hF0;
            PS2_KEY[23:16] = ($urandom_range(0, 1) == 1) ? 8'hE0 : 8'h00;
          end
          3: PS2_KEY[39:32] = 8'($urandom_range(1, 255));
          default: ;
        endcase
        PS2_KEY[64] = ~PS2_KEY[64];
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
